// File: rtl/pc_sequencer.sv
// Fetch-address sequencer: registered PC with branch/jump/call/return
// selection and a circular return-address stack.
module pc_sequencer #(
  parameter int              ADDR_W    = 12,
  parameter int              RAS_DEPTH = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                         clock,
  input  logic                         reset_n,
  input  logic                         stall,
  input  logic                         branch_taken,
  input  logic [ADDR_W-1:0]            branch_target,
  input  logic                         jump,
  input  logic                         call,
  input  logic [ADDR_W-1:0]            jump_target,
  input  logic                         ret,
  output logic [ADDR_W-1:0]            pc,
  output logic [$clog2(RAS_DEPTH):0]   ras_count,
  output logic                         ras_overflow,
  output logic                         ras_underflow
);

  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] pc_inc;
  logic [ADDR_W-1:0] top;
  logic [PTR_W-1:0]  ptr_q, ptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              of_q, of_d;
  logic              uf_q, uf_d;
  logic              push;
  logic              full;
  logic              empty;

  logic [ADDR_W-1:0] stack_q [RAS_DEPTH];

  assign pc_inc = pc_q + ADDR_W'(1);
  assign top    = stack_q[ptr_q - PTR_W'(1)];
  assign full   = (cnt_q == CNT_W'(RAS_DEPTH));
  assign empty  = (cnt_q == '0);

  always_comb begin
    pc_d  = pc_q;
    ptr_d = ptr_q;
    cnt_d = cnt_q;
    of_d  = of_q;
    uf_d  = uf_q;
    push  = 1'b0;
    if (!stall) begin
      priority case (1'b1)
        ret: begin
          if (empty) begin
            pc_d = pc_inc;
            uf_d = 1'b1;
          end else begin
            pc_d  = top;
            ptr_d = ptr_q - PTR_W'(1);
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        call: begin
          // when full the write lands on the oldest slot
          push  = 1'b1;
          pc_d  = jump_target;
          ptr_d = ptr_q + PTR_W'(1);
          if (full) of_d = 1'b1;
          else      cnt_d = cnt_q + CNT_W'(1);
        end
        jump:         pc_d = jump_target;
        branch_taken: pc_d = branch_target;
        default:      pc_d = pc_inc;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pc_q  <= RESET_PC;
      ptr_q <= '0;
      cnt_q <= '0;
      of_q  <= 1'b0;
      uf_q  <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
      of_q  <= of_d;
      uf_q  <= uf_d;
    end
  end

  always_ff @(posedge clock) begin
    if (push && reset_n) stack_q[ptr_q] <= pc_inc;
  end

  assign pc            = pc_q;
  assign ras_count     = cnt_q;
  assign ras_overflow  = of_q;
  assign ras_underflow = uf_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed scenarios plus random traffic
// checked against a queue-based return-stack model.
module tb_pc_sequencer;

  localparam int AW  = 12;
  localparam int DEP = 8;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          stall = 1'b0;
  logic          branch_taken = 1'b0;
  logic [AW-1:0] branch_target = '0;
  logic          jump = 1'b0;
  logic          call = 1'b0;
  logic [AW-1:0] jump_target = '0;
  logic          ret = 1'b0;
  logic [AW-1:0] pc;
  logic [3:0]    ras_count;
  logic          ras_overflow;
  logic          ras_underflow;

  int n_tests = 0;
  int n_fail  = 0;

  int mpc;
  int mq[$];
  bit mof;
  bit muf;

  pc_sequencer #(.ADDR_W(AW), .RAS_DEPTH(DEP), .RESET_PC(12'h000)) dut (
    .clock(clock), .reset_n(reset_n), .stall(stall),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .jump(jump), .call(call), .jump_target(jump_target), .ret(ret),
    .pc(pc), .ras_count(ras_count),
    .ras_overflow(ras_overflow), .ras_underflow(ras_underflow)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_state(input string tag);
    chk({tag, ".pc"}, int'(pc), mpc);
    chk({tag, ".cnt"}, int'(ras_count), mq.size());
    chk({tag, ".ovf"}, int'(ras_overflow), int'(mof));
    chk({tag, ".udf"}, int'(ras_underflow), int'(muf));
  endtask

  function automatic void model_reset();
    mpc = 0;
    mq.delete();
    mof = 0;
    muf = 0;
  endfunction

  function automatic void model_step();
    if (stall) return;
    if (ret) begin
      if (mq.size() > 0) mpc = mq.pop_back();
      else begin
        mpc = (mpc + 1) % 4096;
        muf = 1;
      end
    end else if (call) begin
      mq.push_back((mpc + 1) % 4096);
      if (mq.size() > DEP) begin
        void'(mq.pop_front());
        mof = 1;
      end
      mpc = int'(jump_target);
    end else if (jump) mpc = int'(jump_target);
    else if (branch_taken) mpc = int'(branch_target);
    else mpc = (mpc + 1) % 4096;
  endfunction

  // called at a negedge; returns at the following negedge
  task automatic step(input bit s, input bit r, input bit c,
                      input bit j, input bit b,
                      input int jt, input int bt, input string tag);
    stall = s; ret = r; call = c; jump = j; branch_taken = b;
    jump_target = AW'(jt); branch_target = AW'(bt);
    @(posedge clock);
    model_step();
    @(negedge clock);
    chk_state(tag);
  endtask

  task automatic idle(input string tag);
    step(0, 0, 0, 0, 0, 0, 0, tag);
  endtask

  task automatic goto_pc(input int a);
    step(0, 0, 0, 1, 0, a, 0, "goto");
  endtask

  task automatic do_reset();
    reset_n = 0;
    #1;
    model_reset();
    chk_state("rst_async");
    @(posedge clock);
    @(negedge clock);
    chk_state("rst_hold");
    stall = 0; ret = 0; call = 0; jump = 0; branch_taken = 0;
    reset_n = 1;
  endtask

  initial begin
    model_reset();
    @(negedge clock);
    do_reset();
    chk("reset_pc", int'(pc), 0);

    for (int i = 1; i <= 5; i++) begin
      idle("seq");
      chk("seq_abs", int'(pc), i);
    end

    goto_pc('hFFE);
    idle("wrap1");
    chk("wrap_fff", int'(pc), 'hFFF);
    idle("wrap2");
    chk("wrap_000", int'(pc), 0);
    idle("wrap3");

    goto_pc('h010);
    step(0, 0, 1, 0, 0, 'h200, 0, "call");
    chk("call_pc", int'(pc), 'h200);
    idle("c1");
    idle("c2");
    step(0, 1, 0, 0, 0, 0, 0, "ret");
    chk("ret_pc", int'(pc), 'h011);

    do_reset();
    for (int i = 0; i < 9; i++)
      step(0, 0, 1, 0, 0, 'h100 + i, 0, "ovf_call");
    chk("ovf_flag", int'(ras_overflow), 1);
    chk("ovf_cnt", int'(ras_count), 8);
    for (int i = 0; i < 8; i++) begin
      step(0, 1, 0, 0, 0, 0, 0, "ovf_ret");
      chk("ovf_ret_abs", int'(pc), 'h108 - i);
    end
    step(0, 1, 0, 0, 0, 0, 0, "udf_ret");
    chk("udf_flag", int'(ras_underflow), 1);
    chk("udf_pc", int'(pc), 'h102);

    goto_pc('h04F);
    step(0, 0, 1, 0, 0, 'h050, 0, "stall_setup");
    for (int i = 0; i < 3; i++)
      step(1, 1, 1, 0, 1, 'h123, 'h3AA, "stall");
    chk("stall_pc", int'(pc), 'h050);
    step(0, 0, 0, 0, 1, 0, 'h3AA, "release");
    chk("release_pc", int'(pc), 'h3AA);

    step(0, 0, 0, 1, 1, 'h0A0, 'h0B0, "jmp_vs_br");
    chk("jmp_pc", int'(pc), 'h0A0);
    do_reset();
    goto_pc('h0A0);
    step(0, 0, 1, 0, 0, 'h300, 0, "push_0a1");
    step(0, 1, 1, 0, 0, 'h400, 0, "ret_call");
    chk("retcall_pc", int'(pc), 'h0A1);
    chk("retcall_cnt", int'(ras_count), 0);

    step(0, 0, 1, 0, 0, 'h500, 0, "mid_call");
    call = 1; jump_target = 12'h600;
    do_reset();

    for (int i = 0; i < 2000; i++) begin
      int p = $urandom_range(99);
      step($urandom_range(99) < 12,
           p < 22, p >= 15 && p < 45, $urandom_range(3) == 0,
           $urandom_range(1) == 1,
           int'($urandom_range(4095)), int'($urandom_range(4095)),
           "rand");
      if (i == 1000) do_reset();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: got 0 expected 1");
    $fatal(1);
  end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
Registered program-counter sequencer that owns the 12-bit fetch address.
- Each cycle it selects the next PC from: sequential increment, branch target, jump target, call target, or return-stack pop.
- It keeps a small circular return-address stack.
- It sits at the front of the fetch stage and drives instruction-memory address; it is the consumer/holder of the sequential-increment address path.

Parameters:
ADDR_W, 12, PC and target width in bits.
RAS_DEPTH, 8, return-address-stack entries (power of two, >=2).
RESET_PC, 12'h000, PC value loaded on reset.

Ports:
clock  input  1  rising-edge clock.
reset_n  input  1  asynchronous active-low reset.
stall  input  1  hold PC and stack unchanged this cycle.
branch_taken  input  1  redirect to branch_target.
branch_target  input  ADDR_W  conditional branch destination.
jump  input  1  unconditional redirect to jump_target.
call  input  1  push pc+1, redirect to jump_target.
jump_target  input  ADDR_W  destination for jump and call.
ret  input  1  pop return stack, redirect to popped address.
pc  output  ADDR_W  current fetch address (registered).
ras_count  output  $clog2(RAS_DEPTH)+1  valid stack entries, 0..RAS_DEPTH.
ras_overflow  output  1  sticky: a push occurred while full.
ras_underflow  output  1  sticky: a pop occurred while empty.

Behaviour:
- Reset (reset_n low, asynchronous, takes effect immediately; deassertion sampled on the next clock edge):
  - pc=RESET_PC, ras_count=0, ras_overflow=0, ras_underflow=0, stack pointer=0.
  - Stack storage contents are don't-care.
  - Reset mid-call/ret discards the operation entirely.
- All state updates on the rising clock edge. One-cycle latency: a control input sampled at edge N is reflected on pc after edge N.
- stall=1 overrides all other inputs: pc, stack, count and flags hold. Control inputs are ignored, not queued.
- When stall=0, the next-PC priority (highest first) is:
  1. ret: if ras_count>0, pc<=top entry, pointer decrements, ras_count-1. If ras_count=0, pc<=pc+1, ras_underflow<=1, count stays 0.
  2. call: stack[ptr]<=pc+1, pointer increments mod RAS_DEPTH, pc<=jump_target. If ras_count=RAS_DEPTH, the oldest entry is overwritten (circular), count stays RAS_DEPTH, and ras_overflow<=1.
  3. jump: pc<=jump_target.
  4. branch_taken: pc<=branch_target.
  5. none: pc<=pc+1.
- Lower-priority inputs asserted together with a higher one are ignored. ret+call in the same cycle performs the pop only; no push and no count change beyond the pop.
- Arithmetic: pc+1 is computed modulo 2^ADDR_W. 12'hFFF+1 = 12'h000, with no carry out and no flag. The pushed return address wraps the same way.
- The stack is LIFO. After overflow, pops return the most recent RAS_DEPTH addresses in reverse push order. Further pops then underflow.
- ras_overflow and ras_underflow are sticky; only reset clears them.
- Targets are used unmodified, with no alignment or range check.

Test Plan:
- Reset then 5 unstalled idle cycles -> pc sequence 000,001,002,003,004,005; ras_count=0; flags 0.
- pc=FFE idle 3 cycles -> FFF, 000, 001; no flag set.
- At pc=010, call with jump_target=200 -> pc=200, ras_count=1. Two idle cycles -> 201, 202. Then ret -> pc=011, ras_count=0.
- From pc=000, 9 consecutive calls (RAS_DEPTH=8) with targets 100..108 -> ras_overflow=1, ras_count=8. Then 8 rets return 108,107,...,101 in order. A 9th ret sets ras_underflow=1 and pc advances by +1.
- At pc=050, assert stall with ret, call, branch_taken (target 3AA) for 3 cycles -> pc holds 050 and ras_count is unchanged. Release with only branch_taken, target 3AA -> pc=3AA.
- Simultaneous jump (target 0A0) and branch_taken (target 0B0) -> pc=0A0. Then ret+call with one stacked entry 0A1 -> pc=0A1, ras_count=0. Assert reset_n low mid-sequence -> pc=000 immediately, count 0, flags 0.
